array_map_sequencer: RTL and testbench

//  Sequences a shared single-function unit (FU) over an array: for i in [0,len) computes y[i] = f(x[i]).

---
 rtl/array_map_pkg.sv | 28 ++
 rtl/array_map_sync_fifo2.sv | 50 +++++
 rtl/array_map_sequencer.sv | 154 +++++++++++++++
 tb/tb_array_map_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_map_pkg.sv
// Shared sizing, state encoding and request bundle
// for the array map sequencer and its operand buffer.
package array_map_pkg;

    localparam int DEPTH   = 10;
    localparam int WIDTH   = 32;
    localparam int MAX_OUT = 4;
    localparam int IDXW    = $clog2(DEPTH);
    localparam int CW      = IDXW + 1;
    localparam int REQW    = WIDTH + IDXW;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_e;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [IDXW-1:0]  tag;
    } fu_req_t;

    function automatic logic [CW-1:0] sat_len(input logic [CW-1:0] l);
        return (l > CW'(DEPTH)) ? CW'(DEPTH) : l;
    endfunction

endpackage

// File: rtl/array_map_sync_fifo2.sv
// Two-entry operand buffer between the source read
// return and the FU request port.
module sync_fifo2
    import array_map_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [REQW-1:0] in_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [REQW-1:0] out_data_o,
    output logic [1:0]      count_o
);

    logic [REQW-1:0] mem_q [2];
    logic            wp_q;
    logic            rp_q;
    logic [1:0]      cnt_q;
    logic            push;
    logic            pop;

    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rp_q];
    assign count_o     = cnt_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wp_q] <= in_data_i;
                wp_q        <= ~wp_q;
            end
            if (pop) begin
                rp_q <= ~rp_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/array_map_sequencer.sv
// Walks x[0..n-1] through a shared FU with bounded
// requests in flight and writes results to y by tag.
module array_map_sequencer
    import array_map_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDXW:0]    len,
    output logic             busy,
    output logic             done,
    output logic             x_rd_en,
    output logic [IDXW-1:0]  x_rd_idx,
    input  logic [WIDTH-1:0] x_rd_data,
    output logic             fu_req_valid,
    input  logic             fu_req_ready,
    output logic [WIDTH-1:0] fu_req_data,
    output logic [IDXW-1:0]  fu_req_tag,
    input  logic             fu_rsp_valid,
    input  logic [WIDTH-1:0] fu_rsp_data,
    input  logic [IDXW-1:0]  fu_rsp_tag,
    output logic             y_wr_en,
    output logic [IDXW-1:0]  y_wr_idx,
    output logic [WIDTH-1:0] y_wr_data
);

    localparam logic [CW-1:0] MaxOut = CW'(MAX_OUT);

    seq_state_e       state_q, state_d;
    logic [CW-1:0]    n_q, n_d;
    logic [CW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    out_q, out_d;
    logic [CW-1:0]    wr_q, wr_d;
    logic             rd_pend_q;
    logic [IDXW-1:0]  rd_tag_q;
    logic             y_en_q;
    logic [IDXW-1:0]  y_idx_q;
    logic [WIDTH-1:0] y_data_q;

    logic [CW-1:0]    sat_n;
    logic [CW-1:0]    inflight;
    fu_req_t          push_req;
    fu_req_t          head;
    logic [1:0]       fcnt;
    logic             push_ready;
    logic             act;
    logic             hs;
    logic             rsp;
    logic             room;
    logic             credit;

    assign sat_n    = sat_len(len);
    assign push_req = '{data: x_rd_data, tag: rd_tag_q};

    sync_fifo2 u_buf (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (rd_pend_q),
        .in_ready_o  (push_ready),
        .in_data_i   (push_req),
        .out_valid_o (fu_req_valid),
        .out_ready_i (fu_req_ready),
        .out_data_o  (head),
        .count_o     (fcnt)
    );

    assign fu_req_data = head.data;
    assign fu_req_tag  = head.tag;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign x_rd_idx    = rp_q[IDXW-1:0];
    assign y_wr_en     = y_en_q;
    assign y_wr_idx    = y_idx_q;
    assign y_wr_data   = y_data_q;

    assign act = (state_q == RUN) || (state_q == DRAIN);
    assign hs  = fu_req_valid && fu_req_ready;
    assign rsp = act && fu_rsp_valid;

    // Everything between the read port and the FU counts against the cap,
    // and a response this cycle frees one credit for a read this cycle.
    assign inflight = out_q + CW'(fcnt) + CW'(rd_pend_q);
    assign credit   = inflight < (MaxOut + CW'(rsp));
    assign room     = rd_pend_q ? (fcnt == {1'b0, hs})
                                : (push_ready || hs);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        rp_d    = rp_q;
        x_rd_en = 1'b0;
        out_d   = out_q + CW'(hs) - CW'(rsp);
        wr_d    = wr_q + CW'(rsp);
        unique case (state_q)
            IDLE: begin
                out_d = '0;
                wr_d  = '0;
                if (start) begin
                    n_d     = sat_n;
                    rp_d    = '0;
                    state_d = (sat_n == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                x_rd_en = (rp_q != n_q) && room && credit;
                if (x_rd_en) begin
                    rp_d = rp_q + CW'(1);
                end else if (rp_q == n_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_q == n_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            rp_q      <= '0;
            out_q     <= '0;
            wr_q      <= '0;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= '0;
            y_en_q    <= 1'b0;
            y_idx_q   <= '0;
            y_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            rp_q      <= rp_d;
            out_q     <= out_d;
            wr_q      <= wr_d;
            rd_pend_q <= x_rd_en;
            rd_tag_q  <= x_rd_idx;
            y_en_q    <= rsp;
            if (rsp) begin
                y_idx_q  <= fu_rsp_tag;
                y_data_q <= fu_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_array_map_sequencer.sv
// Directed bench for array_map_sequencer with source RAM
// and FU models (in-order latency 1, or batched out-of-order).
module tb_array_map_sequencer;
    import array_map_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [IDXW:0]    len = '0;
    logic             busy;
    logic             done;
    logic             x_rd_en;
    logic [IDXW-1:0]  x_rd_idx;
    logic [WIDTH-1:0] x_rd_data = '0;
    logic             fu_req_valid;
    logic             fu_req_ready = 1'b1;
    logic [WIDTH-1:0] fu_req_data;
    logic [IDXW-1:0]  fu_req_tag;
    logic             fu_rsp_valid = 1'b0;
    logic [WIDTH-1:0] fu_rsp_data = '0;
    logic [IDXW-1:0]  fu_rsp_tag = '0;
    logic             y_wr_en;
    logic [IDXW-1:0]  y_wr_idx;
    logic [WIDTH-1:0] y_wr_data;

    array_map_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .x_rd_en      (x_rd_en),
        .x_rd_idx     (x_rd_idx),
        .x_rd_data    (x_rd_data),
        .fu_req_valid (fu_req_valid),
        .fu_req_ready (fu_req_ready),
        .fu_req_data  (fu_req_data),
        .fu_req_tag   (fu_req_tag),
        .fu_rsp_valid (fu_rsp_valid),
        .fu_rsp_data  (fu_rsp_data),
        .fu_rsp_tag   (fu_rsp_tag),
        .y_wr_en      (y_wr_en),
        .y_wr_idx     (y_wr_idx),
        .y_wr_data    (y_wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] xval(input int i);
        return 32'h1234_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    function automatic logic [WIDTH-1:0] ffun(input logic [WIDTH-1:0] x);
        return x * 32'd3 + 32'h55;
    endfunction

    typedef struct {
        int len;
        bit tog;
        bit ooo;
        bit mid;
        bit ordered;
        bit tput;
        int exp_n;
        int exp_first[4];
    } vec_t;

    typedef logic [IDXW+WIDTH-1:0] rsp_t;

    int   nvec = 0;
    int   nfail = 0;
    int   cyc = 0;
    bit   fu_ooo = 1'b0;
    bit   rdy_tog = 1'b0;
    int   rph = 0;
    int   idle = 0;
    rsp_t col[$];
    rsp_t rel[$];

    int   rd_idx[$];
    int   rd_cyc[$];
    int   wr_idx[$];
    logic [WIDTH-1:0] wr_dat[$];
    int   hs_cnt, inflight, max_if, stall_bad, bad_req;
    int   done_cnt, done_cyc, wr_at_done, busy_cnt;
    bit   prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_d;
    logic [IDXW-1:0]  prev_t;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rph          <= (rph == 2) ? 0 : rph + 1;
        fu_req_ready <= !rdy_tog || (rph == 2);
    end

    always @(posedge clk) begin
        x_rd_data <= x_rd_en ? xval(int'(x_rd_idx)) : '0;
    end

    // Out-of-order mode returns each batch of 4 as positions 3,1,0,2.
    always @(posedge clk) begin
        rsp_t r;
        if (!fu_ooo) begin
            fu_rsp_valid <= fu_req_valid && fu_req_ready;
            fu_rsp_tag   <= fu_req_tag;
            fu_rsp_data  <= ffun(fu_req_data);
        end else begin
            if (fu_req_valid && fu_req_ready) begin
                col.push_back({fu_req_tag, ffun(fu_req_data)});
                idle = 0;
            end else if (idle < 100) begin
                idle++;
            end
            if (col.size() == 4) begin
                rel.push_back(col[3]);
                rel.push_back(col[1]);
                rel.push_back(col[0]);
                rel.push_back(col[2]);
                col.delete();
            end else if (col.size() != 0 && idle >= 4) begin
                while (col.size() != 0) rel.push_back(col.pop_back());
            end
            if (rel.size() != 0) begin
                r = rel.pop_front();
                fu_rsp_valid <= 1'b1;
                fu_rsp_tag   <= r[IDXW+WIDTH-1:WIDTH];
                fu_rsp_data  <= r[WIDTH-1:0];
            end else begin
                fu_rsp_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (x_rd_en) begin
            rd_idx.push_back(int'(x_rd_idx));
            rd_cyc.push_back(cyc);
        end
        if (fu_rsp_valid && busy && inflight > 0) inflight--;
        if (fu_req_valid && fu_req_ready) begin
            hs_cnt++;
            inflight++;
            if (fu_req_data != xval(int'(fu_req_tag))) bad_req++;
        end
        if (inflight > max_if) max_if = inflight;
        if (prev_stall && (!fu_req_valid || fu_req_data != prev_d
                           || fu_req_tag != prev_t)) stall_bad++;
        prev_stall = fu_req_valid && !fu_req_ready;
        prev_d     = fu_req_data;
        prev_t     = fu_req_tag;
        if (y_wr_en) begin
            wr_idx.push_back(int'(y_wr_idx));
            wr_dat.push_back(y_wr_data);
        end
        if (done) begin
            done_cnt++;
            done_cyc   = cyc;
            wr_at_done = wr_idx.size();
        end
        if (busy) busy_cnt++;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_logs();
        rd_idx.delete();
        rd_cyc.delete();
        wr_idx.delete();
        wr_dat.delete();
        hs_cnt     = 0;
        inflight   = 0;
        max_if     = 0;
        stall_bad  = 0;
        bad_req    = 0;
        done_cnt   = 0;
        done_cyc   = -1;
        wr_at_done = -1;
        busy_cnt   = 0;
        prev_stall = 1'b0;
    endtask

    task automatic run_rec(input int id, input vec_t v);
        int t0, k, bad, n4;
        int seen[DEPTH];
        string p;
        p = $sformatf("v%0d", id);
        fu_ooo  = v.ooo;
        rdy_tog = v.tog;
        @(negedge clk); #1;
        clear_logs();
        start = 1'b1;
        len   = CW'(v.len);
        t0    = cyc;
        k     = 0;
        while (done_cnt == 0 && k < 400) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (v.mid && k == 4) begin
                start = 1'b1;
                len   = CW'(3);
            end
            k++;
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk({p, ".done_pulses"}, done_cnt, 1);
        chk({p, ".reads"}, rd_idx.size(), v.exp_n);
        bad = 0;
        foreach (rd_idx[i]) if (rd_idx[i] != i) bad++;
        chk({p, ".read_order"}, bad, 0);
        chk({p, ".issues"}, hs_cnt, v.exp_n);
        chk({p, ".writes"}, wr_idx.size(), v.exp_n);
        bad = 0;
        foreach (seen[i]) seen[i] = 0;
        foreach (wr_idx[i]) begin
            if (wr_idx[i] >= v.exp_n) bad++;
            else seen[wr_idx[i]]++;
            if (wr_dat[i] != ffun(xval(wr_idx[i]))) bad++;
        end
        for (int i = 0; i < v.exp_n; i++) if (seen[i] != 1) bad++;
        chk({p, ".write_set"}, bad, 0);
        n4  = (v.exp_n < 4) ? v.exp_n : 4;
        bad = 0;
        for (int i = 0; i < n4; i++)
            if (i >= wr_idx.size() || wr_idx[i] != v.exp_first[i]) bad++;
        chk({p, ".first_writes"}, bad, 0);
        if (v.ordered) begin
            bad = 0;
            foreach (wr_idx[i]) if (wr_idx[i] != i) bad++;
            chk({p, ".write_order"}, bad, 0);
        end
        if (v.tput && rd_cyc.size() > 0)
            chk({p, ".read_span"}, rd_cyc[rd_cyc.size()-1] - rd_cyc[0],
                v.exp_n - 1);
        chk({p, ".max_inflight_ok"}, max_if <= MAX_OUT, 1);
        chk({p, ".stall_stable"}, stall_bad, 0);
        chk({p, ".req_data"}, bad_req, 0);
        chk({p, ".writes_at_done"}, wr_at_done, v.exp_n);
        chk({p, ".busy_cycles"}, busy_cnt, done_cyc - t0);
        if (v.exp_n == 0) chk({p, ".done_latency"}, done_cyc - t0, 1);
    endtask

    vec_t vecs[6];
    vec_t v3;

    initial begin
        int k;
        vecs[0] = '{10, 0, 0, 0, 1, 1, 10, '{0, 1, 2, 3}};
        vecs[1] = '{ 0, 0, 0, 0, 1, 0,  0, '{0, 0, 0, 0}};
        vecs[2] = '{10, 1, 0, 0, 1, 0, 10, '{0, 1, 2, 3}};
        vecs[3] = '{10, 0, 1, 0, 0, 0, 10, '{3, 1, 0, 2}};
        vecs[4] = '{15, 0, 0, 1, 1, 1, 10, '{0, 1, 2, 3}};
        vecs[5] = '{ 7, 1, 1, 0, 0, 0,  7, '{3, 1, 0, 2}};
        v3      = '{ 3, 0, 0, 0, 1, 1,  3, '{0, 1, 2, 0}};
        clear_logs();

        repeat (3) @(negedge clk);
        #1;
        chk("reset_state", {busy, done, x_rd_en, fu_req_valid, y_wr_en,
                            x_rd_idx, y_wr_idx}, 0);
        rst = 1'b0;

        foreach (vecs[i]) run_rec(i, vecs[i]);

        fu_ooo  = 1'b1;
        rdy_tog = 1'b0;
        @(negedge clk); #1;
        clear_logs();
        start = 1'b1;
        len   = CW'(10);
        @(negedge clk); #1;
        start = 1'b0;
        k = 0;
        while (hs_cnt < 5 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        chk("rst.five_issued", hs_cnt >= 5, 1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst.outputs", {busy, done, x_rd_en, fu_req_valid, y_wr_en}, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        clear_logs();
        repeat (12) @(negedge clk);
        #1;
        chk("rst.stale_writes", wr_idx.size(), 0);
        chk("rst.stale_busy", busy_cnt, 0);
        chk("rst.stale_done", done_cnt, 0);

        run_rec(6, v3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
